// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and width helper for the serial transmit controller.
`default_nettype none

package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Counter widths never drop below one bit so degenerate parameters still elaborate.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_core.sv
// piso_shift_core: parallel-load shift register, shifts left with zero fill, MSB out.
`default_nettype none

module piso_shift_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: valid/ready word intake, MSB-first serialisation with per-bit
// clock stretching and an idle gap after each word.
`default_nettype none

module piso_tx_ctrl
    import piso_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_BITS     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             frame,
    output logic             busy,
    output logic             word_done
);

    localparam int DW = clog2_min1(CLKS_PER_BIT);
    localparam int BW = clog2_min1(WIDTH);
    localparam int GW = clog2_min1(GAP_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam bit            HAS_GAP  = (GAP_BITS > 0);

    state_t        state, next_state;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          div_term, last_bit, gap_last, handshake;
    logic          sr_load, sr_shift, sr_clear, sr_msb;

    assign div_term  = (div_cnt == DIV_LAST);
    assign last_bit  = (bit_cnt == BIT_LAST);
    assign gap_last  = (gap_cnt == GAP_LAST);
    assign handshake = (state == ST_IDLE) && in_ready && in_valid && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == ST_IDLE);
        end
    end

    // word_done is not masked by abort: a word whose last bit period completes is reported.
    always_comb begin
        next_state = state;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_clear   = 1'b0;
        word_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    sr_load    = 1'b1;
                    next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_term) begin
                    sr_shift = 1'b1;
                    if (last_bit) begin
                        word_done  = 1'b1;
                        next_state = HAS_GAP ? ST_GAP : ST_IDLE;
                    end
                end
                if (abort) begin
                    sr_clear   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (abort || (div_term && gap_last)) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                sr_clear   = 1'b1;
                next_state = ST_IDLE;
            end
        endcase
    end

    // Any state change restarts all counters, so none can run past its terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (next_state != state) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (state != ST_IDLE) begin
            if (div_term) begin
                div_cnt <= '0;
                if (state == ST_SHIFT) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (state == ST_GAP) begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    piso_shift_core #(
        .WIDTH (WIDTH)
    ) u_shift_core (
        .clk       (clk),
        .reset     (reset),
        .clear     (sr_clear),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (in_data),
        .msb       (sr_msb)
    );

    assign frame   = (state == ST_SHIFT);
    assign busy    = (state == ST_SHIFT) || (state == ST_GAP);
    assign ser_out = frame & sr_msb;

endmodule

`default_nettype wire

// File: tb/tb_piso_tx_ctrl.sv
// tb_piso_tx_ctrl: directed checks of piso_tx_ctrl with default parameters and
// with a 4-bit, one-clock-per-bit, no-gap instance.
`default_nettype none

module tb_piso_tx_ctrl;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       abort    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready, ser_out, frame, busy, word_done;

    logic       abort4    = 1'b0;
    logic       in_valid4 = 1'b0;
    logic [3:0] in_data4  = 4'h0;
    logic       in_ready4, ser_out4, frame4, busy4, word_done4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_tx_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_out   (ser_out),
        .frame     (frame),
        .busy      (busy),
        .word_done (word_done)
    );

    piso_tx_ctrl #(
        .WIDTH        (4),
        .CLKS_PER_BIT (1),
        .GAP_BITS     (0)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .abort     (abort4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .ser_out   (ser_out4),
        .frame     (frame4),
        .busy      (busy4),
        .word_done (word_done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one word through the default instance and checks every cycle of it.
    task automatic send_word(input logic [7:0] d, input string tag);
        in_data  = d;
        in_valid = 1'b1;
        check({tag, " ready_before"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        check({tag, " ready_after_hs"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 4; c++) begin
                check({tag, " ser_out"}, 32'(ser_out), 32'(d[7-i]));
                check({tag, " frame"}, 32'(frame), 32'd1);
                check({tag, " word_done"}, 32'(word_done), (i == 7 && c == 3) ? 32'd1 : 32'd0);
                tick();
            end
        end
        for (int g = 0; g < 4; g++) begin
            check({tag, " gap_busy"}, 32'(busy), 32'd1);
            check({tag, " gap_frame"}, 32'(frame), 32'd0);
            check({tag, " gap_ser"}, 32'(ser_out), 32'd0);
            check({tag, " gap_ready"}, 32'(in_ready), 32'd0);
            tick();
        end
        check({tag, " ready_end"}, 32'(in_ready), 32'd1);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int ones;
        logic [3:0] w4;

        // Reset state
        #12;
        check("rst ser_out", 32'(ser_out), 32'd0);
        check("rst frame", 32'(frame), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst word_done", 32'(word_done), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        check("rst release ready", 32'(in_ready), 32'd0);
        tick();
        check("rst first edge ready", 32'(in_ready), 32'd1);

        // 1: single word A5
        send_word(8'hA5, "t1");

        // 2: in_valid held across FF then 00, period 37
        in_data  = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_data = 8'h00;
        n = 0; ones = 0;
        while (!in_ready && n < 100) begin
            if (ser_out) ones++;
            n++;
            tick();
        end
        check("t2 period1", 32'(n), 32'd36);
        check("t2 ones1", 32'(ones), 32'd32);
        tick();
        check("t2 ready_after_hs2", 32'(in_ready), 32'd0);
        check("t2 frame_hs2", 32'(frame), 32'd1);
        in_valid = 1'b0;
        in_data  = 8'hFF;
        n = 0; ones = 0;
        while (!in_ready && n < 100) begin
            if (ser_out) ones++;
            n++;
            tick();
        end
        check("t2 period2", 32'(n), 32'd36);
        check("t2 ones2", 32'(ones), 32'd0);

        // 3: abort during bit 3 of C3, then 81 intact
        in_data  = 8'hC3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t3 bit0", 32'(ser_out), 32'd1);
        for (int k = 0; k < 12; k++) tick();
        check("t3 bit3", 32'(ser_out), 32'd0);
        check("t3 frame_bit3", 32'(frame), 32'd1);
        tick();
        abort = 1'b1;
        check("t3 no_done", 32'(word_done), 32'd0);
        tick();
        abort = 1'b0;
        check("t3 abort_frame", 32'(frame), 32'd0);
        check("t3 abort_ser", 32'(ser_out), 32'd0);
        check("t3 abort_busy", 32'(busy), 32'd0);
        check("t3 abort_ready", 32'(in_ready), 32'd1);
        check("t3 abort_done", 32'(word_done), 32'd0);
        send_word(8'h81, "t3b");

        // 4: asynchronous reset mid-word
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("t4 pre_frame", 32'(frame), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t4 async_frame", 32'(frame), 32'd0);
        check("t4 async_busy", 32'(busy), 32'd0);
        check("t4 async_ser", 32'(ser_out), 32'd0);
        check("t4 async_ready", 32'(in_ready), 32'd0);
        check("t4 async_done", 32'(word_done), 32'd0);
        tick();
        reset = 1'b0;
        check("t4 release_ready", 32'(in_ready), 32'd0);
        tick();
        check("t4 ready_one_edge", 32'(in_ready), 32'd1);
        check("t4 word_lost", 32'(busy), 32'd0);

        // 5: abort wins over in_valid in IDLE
        in_data  = 8'hFF;
        in_valid = 1'b1;
        abort    = 1'b1;
        tick();
        check("t5 ready", 32'(in_ready), 32'd1);
        check("t5 busy", 32'(busy), 32'd0);
        tick();
        check("t5 ready2", 32'(in_ready), 32'd1);
        check("t5 frame2", 32'(frame), 32'd0);
        in_valid = 1'b0;
        abort    = 1'b0;

        // 6: WIDTH=4, one clock per bit, no gap, back-to-back words
        check("t6 ready", 32'(in_ready4), 32'd1);
        in_data4  = 4'b1001;
        in_valid4 = 1'b1;
        tick();
        w4 = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) in_data4 = 4'b0110;
            check("t6 w1 ser", 32'(ser_out4), 32'(w4[3-i]));
            check("t6 w1 done", 32'(word_done4), (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check("t6 idle_ready", 32'(in_ready4), 32'd1);
        check("t6 idle_busy", 32'(busy4), 32'd0);
        tick();
        w4 = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) in_valid4 = 1'b0;
            check("t6 w2 ser", 32'(ser_out4), 32'(w4[3-i]));
            check("t6 w2 frame", 32'(frame4), 32'd1);
            check("t6 w2 done", 32'(word_done4), (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check("t6 end_ready", 32'(in_ready4), 32'd1);
        tick();
        check("t6 no_third", 32'(busy4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
